demux_collector: RTL and testbench
==================================

DEMUX_COLLECTOR -- requirements
Module: demux_collector

Interface
REQ-001 Parameters: none; data width is fixed at 8 outputs and select width at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 x  input  1  serial data bit to be routed.
REQ-005 s2, s1, s0  input  1 each  manual destination select, index = {s2,s1,s0}, s2 MSB.
REQ-006 valid  input  1  x (and selects) presented this cycle.
REQ-007 auto_mode  input  1  1 = internal pointer chooses destination, 0 = selects choose.
REQ-008 clear  input  1  synchronous frame abort.
REQ-009 y  output  8  registered collected bits, y[i] = bit last routed to index i.
REQ-010 filled  output  8  filled[i] = index i written in the current frame.
REQ-011 ready  output  1  block accepts a write this cycle.
REQ-012 done  output  1  one-cycle frame-complete pulse.

Function
REQ-013 Write accepted SHALL occur only on a rising edge with valid=1, ready=1, clear=0.
REQ-014 States SHALL be IDLE (filled=0), COLLECT (0<filled<8'hFF), DONE; ready=1 in IDLE and COLLECT, 0 in DONE.
REQ-015 Destination index SHALL be {s2,s1,s0} when the frame mode is manual, internal 3-bit pointer ptr when the frame mode is auto.
REQ-016 Frame mode SHALL be latched from auto_mode on the first accepted write out of IDLE; auto_mode changes during COLLECT SHALL be ignored.
REQ-017 On accepted write: y[idx] <= x, filled[idx] <= 1, other y bits unchanged; result visible the cycle after the edge (1-cycle latency).
REQ-018 Auto mode: ptr starts at 0 each frame, increments by 1 per accepted write, wraps 7->0.
REQ-019 Manual rewrite of an already-filled index SHALL overwrite y[idx], leave filled unchanged, and not advance completion.
REQ-020 IDLE->COLLECT on first accepted write; COLLECT->DONE on the accepted write that makes filled=8'hFF.
REQ-021 In DONE (exactly one cycle): done=1, ready=0, valid ignored; next edge: filled<=0, ptr<=0, state IDLE, done<=0.
REQ-022 done SHALL be 1 only in DONE, i.e. the cycle after the completing write, never two consecutive cycles.
REQ-023 y SHALL hold its value across DONE and into the next frame until individual bits are overwritten.
REQ-024 clear=1 SHALL, at the next edge, set filled=0, ptr=0, state IDLE, done=0, leave y unchanged; clear overrides a simultaneous valid and overrides DONE.
REQ-025 valid with ready=0 SHALL have no effect on any register.

Reset
REQ-026 While rst=1, immediately and independent of clk: y=8'h00, filled=8'h00, ptr=0, latched mode=manual, state IDLE, done=0, ready=1.
REQ-027 rst asserted mid-frame or during DONE SHALL discard the frame with no done pulse; first write after release is a new frame.

Verification
REQ-028 Manual: writes x=1,0,1,0,1,0,1,0 to indices 0..7 in order -> done pulse one cycle after 8th write, y=8'h55, filled returns to 8'h00 the following cycle.
REQ-029 Auto: valid held high 8 cycles with x=1,1,0,0,1,1,0,0, selects random -> y=8'h33, done one cycle, ready low for the DONE cycle, ninth valid ignored.
REQ-030 Manual rewrite: write index 3 with 1, then 0, plus indices 0-2,4-7 -> done only after all 8 distinct indices, y[3]=0.
REQ-031 Clear: 5 auto writes then clear with valid=1 -> filled=8'h00, y keeps 5 written bits, next auto write lands at index 0.
REQ-032 Reset mid-frame: rst pulsed after 4 writes -> y=8'h00, filled=8'h00, done never asserts; mode toggled during COLLECT has no effect on destination.

Source files
------------

// File: rtl/demux_collector.sv
// Serial-bit demultiplexer that routes x into one of eight registered slots and
// signals frame completion once every slot has been written at least once.
module demux_collector (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0,
  input  logic       valid,
  input  logic       auto_mode,
  input  logic       clear,
  output logic [7:0] y,
  output logic [7:0] filled,
  output logic       ready,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       mode;
  logic [2:0] ptr;
  logic       frame_auto;
  logic [2:0] idx;
  logic       accept;
  logic [7:0] filled_next;
  logic       complete;

  // Mode comes straight from auto_mode on the frame's first write, then from the latch.
  always_comb begin
    frame_auto  = (state == IDLE) ? auto_mode : mode;
    idx         = frame_auto ? ptr : {s2, s1, s0};
    accept      = valid && ready && !clear;
    filled_next = filled | (8'h01 << idx);
    complete    = accept && (filled_next == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)   state_next = COLLECT;
        COLLECT: if (complete) state_next = DONE;
        DONE:                  state_next = IDLE;
        default:               state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (state != DONE);
    done  = (state == DONE);
  end

  // y is never cleared by frame end or clear; only reset zeroes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y      <= '0;
      filled <= '0;
      ptr    <= '0;
      mode   <= 1'b0;
    end else if (clear || state == DONE) begin
      filled <= '0;
      ptr    <= '0;
    end else if (accept) begin
      y[idx] <= x;
      filled <= filled_next;
      if (frame_auto) begin
        ptr <= ptr + 3'd1;
      end
      if (state == IDLE) begin
        mode <= auto_mode;
      end
    end
  end

endmodule

// File: tb/tb_demux_collector.sv
// Directed self-checking bench for demux_collector: manual and auto frames,
// rewrite, clear, and asynchronous reset behaviour.
module tb_demux_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       x;
  logic       s2, s1, s0;
  logic       valid;
  logic       auto_mode;
  logic       clear;
  logic [7:0] y;
  logic [7:0] filled;
  logic       ready;
  logic       done;

  int cmp = 0;
  int mis = 0;

  demux_collector dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .valid     (valid),
    .auto_mode (auto_mode),
    .clear     (clear),
    .y         (y),
    .filled    (filled),
    .ready     (ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

  // Drives one cycle of inputs, waits for the edge, settles 1 time unit after it.
  task automatic cycle(input logic v, input logic [2:0] sel, input logic xb,
                       input logic am, input logic clr);
    valid = v; {s2, s1, s0} = sel; x = xb; auto_mode = am; clear = clr;
    @(posedge clk);
    #1;
    valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; x = 1'b0; {s2, s1, s0} = 3'd0;
    auto_mode = 1'b0; clear = 1'b0;
    #12;
    cmp++; if (y !== 8'h00) begin mis++; $display("FAIL reset_y got %h exp %h", y, 8'h00); end
    cmp++; if (filled !== 8'h00) begin mis++; $display("FAIL reset_filled got %h exp %h", filled, 8'h00); end
    cmp++; if (ready !== 1'b1) begin mis++; $display("FAIL reset_ready got %b exp 1", ready); end
    cmp++; if (done !== 1'b0) begin mis++; $display("FAIL reset_done got %b exp 0", done); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_manual;
    logic [7:0] exp_f;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 3'(i), (i % 2 == 0), 1'b0, 1'b0);
      exp_f = (i == 7) ? 8'hFF : 8'((16'd1 << (i + 1)) - 16'd1);
      cmp++; if (filled !== exp_f) begin mis++; $display("FAIL manual_filled[%0d] got %h exp %h", i, filled, exp_f); end
      cmp++; if (done !== (i == 7)) begin mis++; $display("FAIL manual_done[%0d] got %b exp %b", i, done, (i == 7)); end
    end
    cmp++; if (y !== 8'h55) begin mis++; $display("FAIL manual_y got %h exp %h", y, 8'h55); end
    cmp++; if (ready !== 1'b0) begin mis++; $display("FAIL manual_ready_done got %b exp 0", ready); end
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cmp++; if (done !== 1'b0) begin mis++; $display("FAIL manual_done_after got %b exp 0", done); end
    cmp++; if (filled !== 8'h00) begin mis++; $display("FAIL manual_filled_after got %h exp %h", filled, 8'h00); end
    cmp++; if (y !== 8'h55) begin mis++; $display("FAIL manual_y_hold got %h exp %h", y, 8'h55); end
  endtask

  task automatic test_auto;
    logic [7:0] xs;
    xs = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      // auto_mode drops after the first write; destinations must keep following ptr
      cycle(1'b1, 3'($urandom_range(7)), xs[i], (i == 0), 1'b0);
      cmp++; if (done !== (i == 7)) begin mis++; $display("FAIL auto_done[%0d] got %b exp %b", i, done, (i == 7)); end
    end
    cmp++; if (y !== 8'h33) begin mis++; $display("FAIL auto_y got %h exp %h", y, 8'h33); end
    cmp++; if (ready !== 1'b0) begin mis++; $display("FAIL auto_ready_done got %b exp 0", ready); end
    cycle(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    cmp++; if (y !== 8'h33) begin mis++; $display("FAIL auto_ninth_ignored got %h exp %h", y, 8'h33); end
    cmp++; if (filled !== 8'h00) begin mis++; $display("FAIL auto_filled_after got %h exp %h", filled, 8'h00); end
    cmp++; if (done !== 1'b0) begin mis++; $display("FAIL auto_done_after got %b exp 0", done); end
    cmp++; if (ready !== 1'b1) begin mis++; $display("FAIL auto_ready_after got %b exp 1", ready); end
  endtask

  task automatic test_rewrite;
    logic [2:0] order [7];
    order = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    cycle(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    cmp++; if (filled !== 8'h08) begin mis++; $display("FAIL rewrite_filled got %h exp %h", filled, 8'h08); end
    cmp++; if (y[3] !== 1'b0) begin mis++; $display("FAIL rewrite_y3 got %b exp 0", y[3]); end
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, order[i], 1'b1, 1'b0, 1'b0);
      cmp++; if (done !== (i == 6)) begin mis++; $display("FAIL rewrite_done[%0d] got %b exp %b", i, done, (i == 6)); end
    end
    cmp++; if (y !== 8'hF7) begin mis++; $display("FAIL rewrite_y got %h exp %h", y, 8'hF7); end
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear;
    logic [4:0] xs;
    xs = 5'b01010;
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'd7, xs[i], 1'b1, 1'b0);
    cmp++; if (filled !== 8'h1F) begin mis++; $display("FAIL clear_pre_filled got %h exp %h", filled, 8'h1F); end
    cycle(1'b1, 3'd7, 1'b1, 1'b1, 1'b1);
    cmp++; if (filled !== 8'h00) begin mis++; $display("FAIL clear_filled got %h exp %h", filled, 8'h00); end
    cmp++; if (y !== 8'hEA) begin mis++; $display("FAIL clear_y got %h exp %h", y, 8'hEA); end
    cmp++; if (done !== 1'b0) begin mis++; $display("FAIL clear_done got %b exp 0", done); end
    cycle(1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
    cmp++; if (y !== 8'hEB) begin mis++; $display("FAIL clear_next_y got %h exp %h", y, 8'hEB); end
    cmp++; if (filled !== 8'h01) begin mis++; $display("FAIL clear_next_filled got %h exp %h", filled, 8'h01); end
  endtask

  task automatic test_reset_mid;
    #2 rst = 1'b1;
    #1;
    cmp++; if (y !== 8'h00) begin mis++; $display("FAIL async_rst_y got %h exp %h", y, 8'h00); end
    cmp++; if (filled !== 8'h00) begin mis++; $display("FAIL async_rst_filled got %h exp %h", filled, 8'h00); end
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    cmp++; if (filled !== 8'h0F) begin mis++; $display("FAIL mode_latch_filled got %h exp %h", filled, 8'h0F); end
    cmp++; if (y !== 8'h0B) begin mis++; $display("FAIL mode_latch_y got %h exp %h", y, 8'h0B); end
    #2 rst = 1'b1;
    #1;
    cmp++; if (y !== 8'h00) begin mis++; $display("FAIL mid_rst_y got %h exp %h", y, 8'h00); end
    cmp++; if (filled !== 8'h00) begin mis++; $display("FAIL mid_rst_filled got %h exp %h", filled, 8'h00); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      cmp++; if (done !== 1'b0) begin mis++; $display("FAIL mid_rst_no_done[%0d] got %b exp 0", i, done); end
    end
    cycle(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    cmp++; if (filled !== 8'h20) begin mis++; $display("FAIL new_frame_filled got %h exp %h", filled, 8'h20); end
    cmp++; if (y !== 8'h20) begin mis++; $display("FAIL new_frame_y got %h exp %h", y, 8'h20); end
  endtask

  initial begin
    test_reset;
    test_manual;
    test_auto;
    test_rewrite;
    test_clear;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
